// File: rtl/points_pkg.sv
`default_nettype none
// ============================================================================
// Module      : points_pkg
// Description : Shared types and constants for the points report controller.
// Revision    : 1.0 - initial release
// ============================================================================
package points_pkg;

  // Packet sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SNAP = 2'd2,
    ST_SEND = 2'd3
  } state_t;

  localparam int PKT_LEN_BASE = 20;
  localparam int MAX_POINTS   = 4;
  localparam int COORD_W      = 16;

  // Point counts above MAX_POINTS are treated as MAX_POINTS
  function automatic logic [2:0] clamp_count(input logic [2:0] cnt);
    return (cnt > 3'(MAX_POINTS)) ? 3'(MAX_POINTS) : cnt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vs_edge_div.sv
`default_nettype none
// ============================================================================
// Module      : vs_edge_div
// Description : Registers VGA vertical sync, produces a one-cycle pulse on
//               each falling edge and a "due" pulse once every FRAME_DIV
//               edges.
// Revision    : 1.0 - initial release
// ============================================================================
module vs_edge_div #(
  parameter int FRAME_DIV = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_vs,
  output logic o_edge,
  output logic o_due
);

  localparam logic [7:0] c_div_last = 8'(FRAME_DIV - 1);

  logic       r_vs;
  logic [7:0] r_div;

  // Falling edge: previous sample high, current sample low
  assign o_edge = r_vs & ~i_vs;
  // The edge that wraps the divider back to zero is the due one
  assign o_due  = o_edge & (r_div == c_div_last);

  // VS history register and edge divider
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vs  <= 1'b0;
      r_div <= 8'd0;
    end else begin
      r_vs <= i_vs;
      if (o_edge) begin
        r_div <= (r_div == c_div_last) ? 8'd0 : r_div + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/points_report_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : points_report_ctrl
// Description : Snapshots point-finder coordinates once every FRAME_DIV
//               frames and streams them as a byte packet to a UART TX with
//               valid/ready handshaking.
//               Define POINTS_REPORT_CHECKSUM_EN to append an XOR checksum
//               byte (21-byte packet instead of 20).
// Revision    : 1.0 - initial release
// ============================================================================
module points_report_ctrl
  import points_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         FRAME_DIV = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_vga_vs,
  input  logic [15:0] i_points_h_0,
  input  logic [15:0] i_points_h_1,
  input  logic [15:0] i_points_h_2,
  input  logic [15:0] i_points_h_3,
  input  logic [15:0] i_points_v_0,
  input  logic [15:0] i_points_v_1,
  input  logic [15:0] i_points_v_2,
  input  logic [15:0] i_points_v_3,
  input  logic [2:0]  i_point_count,
  input  logic        i_tx_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  output logic        o_busy,
  output logic [15:0] o_frame_cnt,
  output logic [15:0] o_drop_cnt
);

`ifdef POINTS_REPORT_CHECKSUM_EN
  localparam int c_pkt_len = PKT_LEN_BASE + 1;
`else
  localparam int c_pkt_len = PKT_LEN_BASE;
`endif
  localparam logic [4:0] c_last_idx = 5'(c_pkt_len - 1);

  state_t               r_state;
  logic [7:0]           r_tx_data;
  logic                 r_tx_valid;
  logic                 r_busy;
  logic [15:0]          r_frame_cnt;
  logic [15:0]          r_drop_cnt;
  logic [4:0]           r_idx;
  logic [15:0]          r_snap_fc;
  logic [2:0]           r_snap_cnt;
  logic [COORD_W-1:0]   r_snap_h [MAX_POINTS];
  logic [COORD_W-1:0]   r_snap_v [MAX_POINTS];
`ifdef POINTS_REPORT_CHECKSUM_EN
  logic [7:0]           r_csum;
`endif

  logic                 w_edge;
  logic                 w_due;
  logic                 w_xfer;
  logic [2:0]           w_cnt_clamped;
  logic [4:0]           w_next_idx;
  logic [3:0]           w_off;
  logic [COORD_W-1:0]   w_sel;
  logic [7:0]           w_next_byte;
  logic [COORD_W-1:0]   w_in_h [MAX_POINTS];
  logic [COORD_W-1:0]   w_in_v [MAX_POINTS];

  vs_edge_div #(
    .FRAME_DIV (FRAME_DIV)
  ) u_vs_edge_div (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_vs   (i_vga_vs),
    .o_edge (w_edge),
    .o_due  (w_due)
  );

  assign w_in_h[0] = i_points_h_0;
  assign w_in_h[1] = i_points_h_1;
  assign w_in_h[2] = i_points_h_2;
  assign w_in_h[3] = i_points_h_3;
  assign w_in_v[0] = i_points_v_0;
  assign w_in_v[1] = i_points_v_1;
  assign w_in_v[2] = i_points_v_2;
  assign w_in_v[3] = i_points_v_3;

  assign w_cnt_clamped = clamp_count(i_point_count);
  assign w_xfer        = r_tx_valid & i_tx_ready;
  assign w_next_idx    = r_idx + 5'd1;

  // Byte selector: picks the packet byte for the index about to be presented
  always_comb begin
    w_off       = 4'(w_next_idx - 5'd4);
    w_sel       = '0;
    w_next_byte = 8'h00;
    case (w_next_idx)
      5'd0: w_next_byte = SYNC_BYTE;
      5'd1: w_next_byte = r_snap_fc[7:0];
      5'd2: w_next_byte = r_snap_fc[15:8];
      5'd3: w_next_byte = {5'd0, r_snap_cnt};
`ifdef POINTS_REPORT_CHECKSUM_EN
      // Byte 19 is transferring now, so fold it in on the way out
      5'(PKT_LEN_BASE): w_next_byte = r_csum ^ r_tx_data;
`endif
      default: begin
        if (w_next_idx < 5'(PKT_LEN_BASE)) begin
          // Per point: H lo, H hi, V lo, V hi
          w_sel       = w_off[1] ? r_snap_v[w_off[3:2]] : r_snap_h[w_off[3:2]];
          w_next_byte = w_off[0] ? w_sel[15:8] : w_sel[7:0];
        end
      end
    endcase
  end

  // Packet sequencer with registered handshake outputs and snapshot capture
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_idx      <= 5'd0;
      r_snap_fc  <= 16'd0;
      r_snap_cnt <= 3'd0;
      for (int i = 0; i < MAX_POINTS; i++) begin
        r_snap_h[i] <= '0;
        r_snap_v[i] <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_due) begin
            r_state <= ST_WAIT;
            r_busy  <= 1'b1;
          end
        end
        ST_WAIT: begin
          // One settling cycle for the point finder after the frame edge
          r_state <= ST_SNAP;
        end
        ST_SNAP: begin
          r_snap_fc  <= r_frame_cnt;
          r_snap_cnt <= w_cnt_clamped;
          for (int i = 0; i < MAX_POINTS; i++) begin
            r_snap_h[i] <= (i < int'(w_cnt_clamped)) ? w_in_h[i] : '0;
            r_snap_v[i] <= (i < int'(w_cnt_clamped)) ? w_in_v[i] : '0;
          end
          r_idx      <= 5'd0;
          r_tx_data  <= SYNC_BYTE;
          r_tx_valid <= 1'b1;
          r_state    <= ST_SEND;
        end
        ST_SEND: begin
          if (w_xfer) begin
            if (r_idx == c_last_idx) begin
              r_tx_valid <= 1'b0;
              r_busy     <= 1'b0;
              r_state    <= ST_IDLE;
            end else begin
              r_idx     <= w_next_idx;
              r_tx_data <= w_next_byte;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Frame counter and saturating drop counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_frame_cnt <= 16'd0;
      r_drop_cnt  <= 16'd0;
    end else begin
      if (w_edge) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
      if (w_due && (r_state != ST_IDLE) && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

`ifdef POINTS_REPORT_CHECKSUM_EN
  // Running XOR of every byte that has been accepted downstream
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_csum <= 8'h00;
    end else if (r_state == ST_SNAP) begin
      r_csum <= 8'h00;
    end else if ((r_state == ST_SEND) && w_xfer) begin
      r_csum <= r_csum ^ r_tx_data;
    end
  end
`endif

  assign o_tx_data   = r_tx_data;
  assign o_tx_valid  = r_tx_valid;
  assign o_busy      = r_busy;
  assign o_frame_cnt = r_frame_cnt;
  assign o_drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_points_report_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_points_report_ctrl
// Description : Directed self-checking bench for points_report_ctrl.
//               Honours POINTS_REPORT_CHECKSUM_EN for the expected length.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_points_report_ctrl;

`ifdef POINTS_REPORT_CHECKSUM_EN
  localparam int PLEN = 21;
`else
  localparam int PLEN = 20;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vs = 1'b0;
  logic        tx_ready = 1'b1;
  logic [2:0]  pcount = 3'd0;
  logic [15:0] th [4];
  logic [15:0] tv [4];

  logic [7:0]  tx_data,  tx_data3;
  logic        tx_valid, tx_valid3;
  logic        busy,     busy3;
  logic [15:0] frame_cnt, frame_cnt3;
  logic [15:0] drop_cnt,  drop_cnt3;

  logic [7:0]  cap  [$];
  logic [7:0]  cap3 [$];
  logic        stall_prev = 1'b0;
  logic [7:0]  stall_data = 8'h00;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  points_report_ctrl #(.SYNC_BYTE(8'hA5), .FRAME_DIV(1)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_vga_vs(vs),
    .i_points_h_0(th[0]), .i_points_h_1(th[1]), .i_points_h_2(th[2]), .i_points_h_3(th[3]),
    .i_points_v_0(tv[0]), .i_points_v_1(tv[1]), .i_points_v_2(tv[2]), .i_points_v_3(tv[3]),
    .i_point_count(pcount), .i_tx_ready(tx_ready),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .o_busy(busy),
    .o_frame_cnt(frame_cnt), .o_drop_cnt(drop_cnt)
  );

  points_report_ctrl #(.SYNC_BYTE(8'hA5), .FRAME_DIV(3)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_vga_vs(vs),
    .i_points_h_0(th[0]), .i_points_h_1(th[1]), .i_points_h_2(th[2]), .i_points_h_3(th[3]),
    .i_points_v_0(tv[0]), .i_points_v_1(tv[1]), .i_points_v_2(tv[2]), .i_points_v_3(tv[3]),
    .i_point_count(pcount), .i_tx_ready(tx_ready),
    .o_tx_data(tx_data3), .o_tx_valid(tx_valid3), .o_busy(busy3),
    .o_frame_cnt(frame_cnt3), .o_drop_cnt(drop_cnt3)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Capture transferred bytes and watch for changes during stalls
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", {31'd0, tx_valid}, 32'd1);
        check("stall_data", {24'd0, tx_data}, {24'd0, stall_data});
      end
      if (tx_valid && tx_ready) cap.push_back(tx_data);
      if (tx_valid3 && tx_ready) cap3.push_back(tx_data3);
      stall_prev = tx_valid && !tx_ready;
      stall_data = tx_data;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    cap.delete();
    cap3.delete();
  endtask

  task automatic vs_fall();
    vs = 1'b1;
    tick(2);
    vs = 1'b0;
    tick(1);
  endtask

  // Wait for BUSY to drop, optionally toggling TX_READY every cycle
  task automatic wait_idle(input string tag, input bit toggle);
    int t;
    t = 0;
    while (busy && t < 300) begin
      if (toggle) tx_ready = ~tx_ready;
      tick(1);
      t++;
    end
    if (t >= 300) check({tag, "_idle_timeout"}, {31'd0, busy}, 32'd0);
    tx_ready = 1'b1;
    tick(2);
  endtask

  // Build the expected packet from the driven inputs and compare it
  task automatic check_pkt(input string tag, input bit use3, input int off, input logic [15:0] fc);
    logic [7:0]  e [0:20];
    logic [2:0]  c;
    logic [15:0] h, v;
    logic [7:0]  x;
    logic [31:0] act;
    int          sz;
    c = (pcount > 3'd4) ? 3'd4 : pcount;
    e[0] = 8'hA5;
    e[1] = fc[7:0];
    e[2] = fc[15:8];
    e[3] = {5'd0, c};
    for (int i = 0; i < 4; i++) begin
      h = (i < int'(c)) ? th[i] : 16'h0000;
      v = (i < int'(c)) ? tv[i] : 16'h0000;
      e[4 + 4*i] = h[7:0];
      e[5 + 4*i] = h[15:8];
      e[6 + 4*i] = v[7:0];
      e[7 + 4*i] = v[15:8];
    end
    x = 8'h00;
    for (int k = 0; k < 20; k++) x = x ^ e[k];
    e[20] = x;
    sz = use3 ? cap3.size() : cap.size();
    for (int k = 0; k < PLEN; k++) begin
      if (off + k < sz) act = {24'd0, use3 ? cap3[off + k] : cap[off + k]};
      else act = 32'hDEAD;
      check($sformatf("%s_b%0d", tag, k), act, {24'd0, e[k]});
    end
  endtask

  initial begin
    th[0] = 16'h0123; tv[0] = 16'h0045;
    th[1] = 16'h0200; tv[1] = 16'h0010;
    th[2] = 16'hBEEF; tv[2] = 16'hCAFE;
    th[3] = 16'h1111; tv[3] = 16'h2222;
    pcount = 3'd2;

    // Reset state
    do_reset();
    check("rst_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_data", {24'd0, tx_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_frame", {16'd0, frame_cnt}, 32'd0);
    check("rst_drop", {16'd0, drop_cnt}, 32'd0);

    // Basic packet, ready tied high; points 2 and 3 masked
    vs_fall();
    check("basic_busy", {31'd0, busy}, 32'd1);
    wait_idle("basic", 1'b0);
    check("basic_len", cap.size(), PLEN);
    check_pkt("basic", 1'b0, 0, 16'd1);
    check("basic_frame", {16'd0, frame_cnt}, 32'd1);

    // Same stimulus with ready toggling each cycle
    do_reset();
    vs_fall();
    wait_idle("toggle", 1'b1);
    check("toggle_len", cap.size(), PLEN);
    check_pkt("toggle", 1'b0, 0, 16'd1);

    // Ready held low across three frames: two drops
    do_reset();
    tx_ready = 1'b0;
    vs_fall();
    vs_fall();
    vs_fall();
    tick(3);
    check("stall_frame", {16'd0, frame_cnt}, 32'd3);
    check("stall_drop", {16'd0, drop_cnt}, 32'd2);
    check("stall_busy", {31'd0, busy}, 32'd1);
    check("stall_nobytes", cap.size(), 0);
    tx_ready = 1'b1;
    wait_idle("stall", 1'b0);
    check("stall_len", cap.size(), PLEN);
    check_pkt("stall", 1'b0, 0, 16'd1);

    // Divider of three over seven frames
    do_reset();
    for (int f = 0; f < 7; f++) begin
      vs_fall();
      tick(30);
    end
    check("div3_len", cap3.size(), 2 * PLEN);
    check_pkt("div3_p0", 1'b1, 0, 16'd3);
    check_pkt("div3_p1", 1'b1, PLEN, 16'd6);
    check("div3_drop", {16'd0, drop_cnt3}, 32'd0);
    check("div3_frame", {16'd0, frame_cnt3}, 32'd7);

    // Reset in the middle of a packet
    do_reset();
    vs_fall();
    for (int t = 0; t < 100 && cap.size() < 5; t++) tick(1);
    check("abort_pre", cap.size(), 5);
    rst = 1'b1;
    tick(1);
    check("abort_valid", {31'd0, tx_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_frame", {16'd0, frame_cnt}, 32'd0);
    check("abort_drop", {16'd0, drop_cnt}, 32'd0);
    rst = 1'b0;
    tick(30);
    check("abort_nomore", cap.size(), 5);
    cap.delete();
    vs_fall();
    wait_idle("abort", 1'b0);
    check("abort_len", cap.size(), PLEN);
    check_pkt("abort", 1'b0, 0, 16'd1);

    // Point count above four is clamped and nothing is masked
    do_reset();
    pcount = 3'd7;
    vs_fall();
    wait_idle("clamp", 1'b0);
    check("clamp_len", cap.size(), PLEN);
    check("clamp_count", {24'd0, (cap.size() > 3) ? cap[3] : 8'hFF}, 32'd4);
    check_pkt("clamp", 1'b0, 0, 16'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
